pc_fetch_unit: RTL

Instruction-fetch sequencer that owns the program counter and is the consumer of jump and branch target fields. It issues word fetches to instruction memory over a valid/ready request channel and collects the responses. It presents fetched instructions to decode through a one-entry output buffer. Redirects from decode/execute (branch, jump, jump-register) flush in-flight work and retarget the PC. It sits between instruction memory and the decode stage.

---
 rtl/pc_fetch_pkg.sv | 23 ++
 rtl/pc_target_calc.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   redirect_kind_t : encoding of the redirect_kind input
//   fetch_state_t   : fetch FSM states (also visible on the fsm_state debug port)
package pc_fetch_pkg;

  localparam int PC_W        = 32;
  localparam int IMM_W       = 26;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BRANCH = 2'b00,
    JUMP   = 2'b01,
    JREG   = 2'b10,
    RSVD   = 2'b11
  } redirect_kind_t;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    DRAIN    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target computation.
// Ports:
//   kind     in  redirect kind (branch / jump / jump-register / reserved)
//   base_pc  in  PC of the control instruction
//   imm      in  immediate field (branch uses [15:0], jump uses all 26 bits)
//   jr_reg   in  jump-register source value
//   target   out redirect target address
//   misalign out jump-register source had non-zero low bits
module pc_target_calc
  import pc_fetch_pkg::*;
(
  input  redirect_kind_t    kind,
  input  logic [PC_W-1:0]   base_pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [PC_W-1:0]   jr_reg,
  output logic [PC_W-1:0]   target,
  output logic              misalign
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_off;

  assign seq_pc = base_pc + PC_W'(INSTR_BYTES);
  // Word offset: sign-extend the 16-bit field and scale by 4 in one concat.
  assign br_off = {{14{imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    target   = seq_pc;
    misalign = 1'b0;
    unique case (kind)
      BRANCH: target = seq_pc + br_off;
      // Jump stays inside the 256 MB region of the sequential PC.
      JUMP:   target = {seq_pc[31:28], imm, 2'b00};
      JREG: begin
        target   = {jr_reg[31:2], 2'b00};
        misalign = (jr_reg[1:0] != 2'b00);
      end
      default: target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch sequencer owning the program counter.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    blocks new fetch requests (redirects still taken)
//   redirect_*               one-cycle redirect strobe plus target operands
//   imem_req_*               fetch request channel to instruction memory
//   imem_rsp_*               fetch response (>= 1 cycle after acceptance)
//   if_valid/pc/instr/ready  one-entry output buffer towards decode
//   misalign_err             sticky: jump-register target had bits [1:0] != 0
//   fsm_state                current fetch FSM state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps valid and payload stable until the transfer,
// except that a redirect withdraws a pending fetch request in its own cycle.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [PC_W-1:0]   redirect_base_pc,
  input  logic [IMM_W-1:0]  redirect_imm,
  input  logic [PC_W-1:0]   redirect_reg,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [31:0]       if_instr,
  input  logic              if_ready,
  output logic              misalign_err,
  output logic [1:0]        fsm_state
);

  fetch_state_t    state_q, state_d;
  redirect_kind_t  kind;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic            target_misalign;
  logic            redirect_take;
  logic            rsp_load;

  assign kind          = redirect_kind_t'(redirect_kind);
  // Reserved kind has no effect on state; it still masks the request below.
  assign redirect_take = redirect_valid && (kind != RSVD);
  assign imem_req_addr = pc_q;
  assign fsm_state     = state_q;

  pc_target_calc u_target (
    .kind     (kind),
    .base_pc  (redirect_base_pc),
    .imm      (redirect_imm),
    .jr_reg   (redirect_reg),
    .target   (target),
    .misalign (target_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    imem_req_valid = 1'b0;
    rsp_load       = 1'b0;
    unique case (state_q)
      FETCH: begin
        // if_ready opens the request so the buffer is free when data returns.
        imem_req_valid = !rst && !stall && !redirect_valid && (!if_valid || if_ready);
        if (imem_req_valid && imem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
          if (!redirect_take) begin
            rsp_load = 1'b1;
            pc_d     = pc_q + PC_W'(INSTR_BYTES);
          end
        end else if (redirect_take) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_take) pc_d = target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (redirect_take) begin
        if_valid <= 1'b0;
      end else if (rsp_load) begin
        if_valid <= 1'b1;
        if_pc    <= pc_q;
        if_instr <= imem_rsp_data;
      end else if (if_valid && if_ready) begin
        if_valid <= 1'b0;
      end
      if (redirect_take && target_misalign) misalign_err <= 1'b1;
    end
  end

endmodule
